// File: rtl/cfg_sccb_sequencer.sv
// -----------------------------------------------------------------------------
// cfg_sccb_sequencer
//
// Walks a register/value table in an external synchronous ROM and issues one
// SCCB/I2C register write per entry through the cfg_i2c_master request
// handshake. Table entries are {reg[15:8], val[7:0]}:
//   16'hFFFF       end of table
//   reg == 8'hF0   delay of val milliseconds (val == 0 is a no-op)
//   anything else  write val to reg
// NACKed writes are reissued up to MAX_RETRY times before the sequence
// stops with an error. The last ROM address also terminates the table once
// its entry has been executed.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             single-cycle pulse, honoured only while idle
//   o_rom_addr          ROM read address (data returns one cycle later)
//   i_rom_data          ROM read data
//   o_wr                write request to the master
//   o_slave_addr        constant 7-bit device address
//   o_reg_addr, o_wdata register address / data of the current write
//   i_busy              master busy
//   i_nack_*            master NACK flags (valid only while i_busy is high)
//   o_active            sequence in progress
//   o_done, o_err       sticky completion / failure flags
//   o_err_index         ROM address of the entry that exhausted its retries
// -----------------------------------------------------------------------------
module cfg_sccb_sequencer #(
  parameter int         T_CLK        = 10,
  parameter logic [6:0] SLAVE_ADDR   = 7'h21,
  parameter int         ROM_AW       = 8,
  parameter int         MAX_RETRY    = 3,
  parameter int         TICKS_PER_MS = 1_000_000 / T_CLK
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_wr,
  output logic [6:0]        o_slave_addr,
  output logic [7:0]        o_reg_addr,
  output logic [7:0]        o_wdata,
  input  logic              i_busy,
  input  logic              i_nack_slave,
  input  logic              i_nack_addr,
  input  logic              i_nack_data,
  output logic              o_active,
  output logic              o_done,
  output logic              o_err,
  output logic [ROM_AW-1:0] o_err_index
);

  localparam int RW_RAW = $clog2(MAX_RETRY + 1);
  localparam int RW     = (RW_RAW < 1) ? 1 : RW_RAW;
  localparam int CW_RAW = $clog2(255 * TICKS_PER_MS + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

  localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [CW-1:0]     TICKS     = CW'(TICKS_PER_MS);
  localparam logic [ROM_AW-1:0] ADDR_LAST = '1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SYNC,
    S_FETCH,
    S_DECODE,
    S_REQ,
    S_XFER,
    S_CHECK,
    S_DELAY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [7:0]        reg_q, reg_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ROM_AW-1:0] err_idx_q, err_idx_d;
  logic              acc_q, acc_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              nack_any;
  logic              last_entry;

  assign nack_any   = i_nack_slave | i_nack_addr | i_nack_data;
  assign last_entry = (addr_q == ADDR_LAST);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    done_d    = done_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    acc_d     = acc_q;
    retry_d   = retry_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          done_d    = 1'b0;
          err_d     = 1'b0;
          err_idx_d = '0;
          addr_d    = '0;
          state_d   = S_SYNC;
        end
      end

      // Covers master initialisation and any transfer orphaned by a reset.
      S_SYNC: begin
        if (!i_busy) state_d = S_FETCH;
      end

      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        if (i_rom_data == 16'hFFFF) begin
          state_d = S_DONE;
        end else if (i_rom_data[15:8] == 8'hF0) begin
          if (i_rom_data[7:0] == 8'd0) begin
            if (last_entry) state_d = S_DONE;
            else begin
              addr_d  = addr_q + 1'b1;
              state_d = S_FETCH;
            end
          end else begin
            cnt_d   = CW'(i_rom_data[7:0]) * TICKS;
            state_d = S_DELAY;
          end
        end else begin
          reg_d   = i_rom_data[15:8];
          wdata_d = i_rom_data[7:0];
          acc_d   = 1'b0;
          retry_d = '0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (i_busy) state_d = S_XFER;
      end

      // The master drops its NACK flags on the edge busy falls, so they are
      // only collected while busy is still high.
      S_XFER: begin
        acc_d = acc_q | (i_busy & nack_any);
        if (!i_busy) state_d = S_CHECK;
      end

      S_CHECK: begin
        if (!acc_q) begin
          retry_d = '0;
          if (last_entry) state_d = S_DONE;
          else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
          end
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 1'b1;
          acc_d   = 1'b0;
          state_d = S_REQ;
        end else begin
          state_d = S_ERROR;
        end
      end

      // Counter is loaded with N*TICKS and the state is left on the cycle it
      // reads 1, giving exactly N*TICKS cycles here.
      S_DELAY: begin
        if (cnt_q <= CW'(1)) begin
          cnt_d = '0;
          if (last_entry) state_d = S_DONE;
          else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      S_ERROR: begin
        err_d     = 1'b1;
        err_idx_d = addr_q;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Registered request: high exactly while the FSM sits in REQ.
    wr_d = (state_d == S_REQ);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      acc_q     <= 1'b0;
      retry_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      acc_q     <= acc_d;
      retry_q   <= retry_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_rom_addr   = addr_q;
  assign o_wr         = wr_q;
  assign o_slave_addr = SLAVE_ADDR;
  assign o_reg_addr   = reg_q;
  assign o_wdata      = wdata_q;
  assign o_active     = (state_q != S_IDLE);
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_err_index  = err_idx_q;

endmodule

// File: tb/tb_cfg_sccb_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for cfg_sccb_sequencer: synchronous ROM model, I2C master model
// with programmable NACK behaviour, table-driven scenarios, hand-written
// corner sequences and randomized tables checked against a table-walk model.
// -----------------------------------------------------------------------------
module tb_cfg_sccb_sequencer;

  localparam int AW   = 4;
  localparam int NROM = 16;
  localparam int MAXR = 3;
  localparam int TPM  = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic          wr;
  logic [6:0]    slave_addr;
  logic [7:0]    reg_addr;
  logic [7:0]    wdata;
  logic          busy;
  logic          nack_s;
  logic          nack_a;
  logic          nack_d;
  logic          active;
  logic          done;
  logic          err;
  logic [AW-1:0] err_idx;

  always #5 clk = ~clk;

  cfg_sccb_sequencer #(
    .T_CLK       (10),
    .SLAVE_ADDR  (7'h21),
    .ROM_AW      (AW),
    .MAX_RETRY   (MAXR),
    .TICKS_PER_MS(TPM)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data),
    .o_wr        (wr),
    .o_slave_addr(slave_addr),
    .o_reg_addr  (reg_addr),
    .o_wdata     (wdata),
    .i_busy      (busy),
    .i_nack_slave(nack_s),
    .i_nack_addr (nack_a),
    .i_nack_data (nack_d),
    .o_active    (active),
    .o_done      (done),
    .o_err       (err),
    .o_err_index (err_idx)
  );

  // ---------------- ROM model (1-cycle latency) ----------------
  logic [15:0] rom [NROM];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // ---------------- I2C master model ----------------
  int          scen      = 0;
  int          m_scen    = 0;
  int          busy_len  = 10;
  int          nack_at   = -1;
  int          nack_cnt  = 0;
  int          nack_kind = 0;
  logic        hold_busy = 1'b0;
  logic        m_busy    = 1'b0;
  logic        m_nack    = 1'b0;
  logic        f_s = 1'b0, f_a = 1'b0, f_d = 1'b0;
  int          m_cnt     = 0;
  logic [7:0]  m_reg     = 8'd0;
  logic [7:0]  m_val     = 8'd0;
  int          attempts [NROM];
  logic [15:0] wlog [$];
  int          stab_bad  = 0;

  assign busy   = m_busy | hold_busy;
  assign nack_s = f_s;
  assign nack_a = f_a;
  assign nack_d = f_d;

  always @(posedge clk) begin
    if (scen != m_scen) begin
      m_scen = scen;
      wlog.delete();
      stab_bad = 0;
      for (int i = 0; i < NROM; i++) attempts[i] = 0;
    end
    if (m_busy && active && !rst)
      if (reg_addr != m_reg || wdata != m_val || slave_addr != 7'h21) stab_bad++;
    if (!m_busy && !hold_busy && wr) begin
      m_busy <= 1'b1;
      m_cnt  <= busy_len;
      m_reg  <= reg_addr;
      m_val  <= wdata;
      wlog.push_back({reg_addr, wdata});
      m_nack <= (int'(rom_addr) == nack_at) && (attempts[rom_addr] < nack_cnt);
      attempts[rom_addr] = attempts[rom_addr] + 1;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy <= 1'b0;
        f_s    <= 1'b0;
        f_a    <= 1'b0;
        f_d    <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 2 && m_nack) begin
          f_s <= (nack_kind == 0);
          f_a <= (nack_kind == 1);
          f_d <= (nack_kind == 2);
        end
      end
    end
  end

  // ---------------- Reference model: walk the table ----------------
  logic [15:0] exp_q [$];
  logic        exp_done;
  logic        exp_err;
  int          exp_idx;

  task automatic model();
    logic [15:0] e;
    int          tries;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_idx  = 0;
    for (int a = 0; a < NROM; a++) begin
      e = rom[a];
      if (e == 16'hFFFF) begin
        exp_done = 1'b1;
        return;
      end
      if (e[15:8] != 8'hF0) begin
        tries = (a == nack_at) ? nack_cnt : 0;
        if (tries > MAXR) begin
          repeat (MAXR + 1) exp_q.push_back(e);
          exp_err = 1'b1;
          exp_idx = a;
          return;
        end
        repeat (tries + 1) exp_q.push_back(e);
      end
    end
    exp_done = 1'b1;
  endtask

  // ---------------- Checking helpers ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    int cyc;
    cyc = 0;
    while (!(done || err) && cyc < 8000) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, " finished"}, longint'(done || err), 1);
  endtask

  task automatic compare_run(input string nm);
    check({nm, " nwr"}, wlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
      check($sformatf("%s wr%0d", nm, i), wlog[i], exp_q[i]);
    check({nm, " done"}, done, exp_done);
    check({nm, " err"}, err, exp_err);
    if (exp_err) check({nm, " err_idx"}, err_idx, exp_idx);
    check({nm, " stable"}, stab_bad, 0);
  endtask

  task automatic run_scen(input string nm);
    scen++;
    model();
    pulse_start();
    check({nm, " flags cleared"}, {done, err}, 0);
    wait_end(nm);
    @(negedge clk);
    compare_run(nm);
  endtask

  // ---------------- Vector table ----------------
  typedef struct {
    logic [79:0] ents;
    int          nat;
    int          ncnt;
    int          nkind;
    int          nwr;
    logic        dn;
    logic        er;
    int          idx;
  } vec_t;

  vec_t vt [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int wr_hi;
    int cyc;
    logic [7:0] rg;
    logic [7:0] vl;
    int r;

    vt[0] = '{80'h1234_5678_9ABC_FFFF_FFFF, -1, 0, 0, 3, 1'b1, 1'b0, 0};
    vt[1] = '{80'h1234_5678_9ABC_FFFF_FFFF,  1, 1, 2, 4, 1'b1, 1'b0, 0};
    vt[2] = '{80'h1234_5678_9ABC_FFFF_FFFF,  2, 99, 0, 6, 1'b0, 1'b1, 2};
    vt[3] = '{80'h1234_F000_5678_FFFF_FFFF, -1, 0, 0, 2, 1'b1, 1'b0, 0};
    vt[4] = '{80'hFFFF_FFFF_FFFF_FFFF_FFFF, -1, 0, 0, 0, 1'b1, 1'b0, 0};
    vt[5] = '{80'hA155_B266_FFFF_FFFF_FFFF,  0, 3, 1, 5, 1'b1, 1'b0, 0};
    vt[6] = '{80'hA155_B266_FFFF_FFFF_FFFF,  0, 4, 1, 4, 1'b0, 1'b1, 0};
    vt[7] = '{80'hFF00_FFFF_FFFF_FFFF_FFFF, -1, 0, 0, 1, 1'b1, 1'b0, 0};
    vt[8] = '{80'h0000_F001_00FF_FFFF_FFFF, -1, 0, 0, 2, 1'b1, 1'b0, 0};

    for (int a = 0; a < NROM; a++) rom[a] = 16'hFFFF;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs",
          {wr, active, done, err, rom_addr, err_idx, reg_addr, wdata}, 0);
    check("slave addr", slave_addr, 7'h21);
    rst = 1'b0;
    @(negedge clk);

    // ---- table-driven scenarios ----
    for (int v = 0; v < 9; v++) begin
      for (int a = 0; a < NROM; a++)
        rom[a] = (a < 5) ? vt[v].ents[79 - 16 * a -: 16] : 16'hFFFF;
      nack_at   = vt[v].nat;
      nack_cnt  = vt[v].ncnt;
      nack_kind = vt[v].nkind;
      busy_len  = (v == 0) ? 39 : $urandom_range(2, 40);
      run_scen($sformatf("vec%0d", v));
      check($sformatf("vec%0d tbl nwr", v), wlog.size(), vt[v].nwr);
      check($sformatf("vec%0d tbl flags", v), {done, err}, {vt[v].dn, vt[v].er});
      if (vt[v].er) check($sformatf("vec%0d tbl idx", v), err_idx, vt[v].idx);
    end

    // ---- delay entry timing: F0_02 at 100 ticks/ms ----
    for (int a = 0; a < NROM; a++) rom[a] = 16'hFFFF;
    rom[0] = 16'h1111; rom[1] = 16'hF002; rom[2] = 16'h2222;
    nack_at = -1; busy_len = 8;
    scen++;
    model();
    pulse_start();
    cyc = 0;
    while (rom_addr != 4'd1 && cyc < 500) begin @(negedge clk); cyc++; end
    n = 0; wr_hi = 0;
    while (rom_addr == 4'd1 && n < 1000) begin
      if (wr) wr_hi++;
      @(negedge clk);
      n++;
    end
    check("delay window", longint'(n >= 201 && n <= 203), 1);
    check("delay no wr", wr_hi, 0);
    wait_end("delay");
    @(negedge clk);
    compare_run("delay");

    // ---- busy held at start, second start mid-sequence ----
    for (int a = 0; a < NROM; a++) rom[a] = 16'hFFFF;
    rom[0] = 16'h3A01; rom[1] = 16'h3B02; rom[2] = 16'h3C03;
    busy_len = 12;
    hold_busy = 1'b1;
    scen++;
    model();
    pulse_start();
    wr_hi = 0; n = 0;
    for (int i = 0; i < 50; i++) begin
      if (wr) wr_hi++;
      if (!active) n++;
      @(negedge clk);
    end
    check("sync no wr", wr_hi, 0);
    check("sync active", n, 0);
    hold_busy = 1'b0;
    cyc = 0;
    while (!m_busy && cyc < 100) begin @(negedge clk); cyc++; end
    pulse_start();
    wait_end("sync");
    @(negedge clk);
    compare_run("sync");

    // ---- reset during XFER, then rerun from address 0 ----
    busy_len = 30;
    scen++;
    pulse_start();
    cyc = 0;
    while (!(m_busy && rom_addr == 4'd1) && cyc < 500) begin @(negedge clk); cyc++; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst mid outputs",
          {wr, active, done, err, rom_addr, err_idx, reg_addr, wdata}, 0);
    rst = 1'b0;
    cyc = 0;
    while (m_busy && cyc < 100) begin @(negedge clk); cyc++; end
    run_scen("rst restart");

    // ---- last ROM address ends the table without a marker ----
    for (int a = 0; a < NROM; a++) rom[a] = {8'h10 + 8'(a), 8'h80 + 8'(a)};
    busy_len = 3;
    run_scen("rom end");
    check("rom end addr", rom_addr, NROM - 1);

    // ---- randomized tables ----
    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < NROM; a++) begin
        r = $urandom_range(0, 99);
        if (r < 12) rom[a] = 16'hFFFF;
        else if (r < 27) rom[a] = {8'hF0, 8'($urandom_range(0, 2))};
        else begin
          rg = 8'($urandom);
          vl = 8'($urandom);
          if (rg == 8'hF0) rg = 8'h11;
          if (rg == 8'hFF && vl == 8'hFF) vl = 8'h00;
          rom[a] = {rg, vl};
        end
      end
      nack_at   = $urandom_range(0, NROM - 1);
      nack_cnt  = $urandom_range(0, 5);
      nack_kind = $urandom_range(0, 2);
      busy_len  = $urandom_range(2, 40);
      run_scen($sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
